// File: rtl/sa_pkg.sv
// Shared definitions for the systolic-array accumulator drain.
//   N_COLS, ACC_W, OUT_W, SHIFT_W : geometry constants
//   drain_state_e                 : drain FSM states
//   requant()                     : shift / round half up / (ReLU) / saturate
// Build option: DRAIN_RELU_EN clamps negative requantized values to 0.
package sa_pkg;

  localparam int N_COLS  = 4;
  localparam int ACC_W   = 32;
  localparam int OUT_W   = 8;
  localparam int SHIFT_W = 5;

  localparam int OUT_MAX = 2 ** (OUT_W - 1) - 1;
  localparam int OUT_MIN = -(2 ** (OUT_W - 1));

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } drain_state_e;

  // All arithmetic runs in ACC_W+1 bits so the rounding add cannot overflow.
  function automatic logic signed [OUT_W-1:0] requant(
    input logic signed [ACC_W-1:0]   acc,
    input logic        [SHIFT_W-1:0] shift
  );
    logic        [SHIFT_W-1:0] sh;
    logic signed [ACC_W:0]     x;
    logic signed [ACC_W:0]     rnd;
    logic signed [ACC_W:0]     t;
    logic signed [ACC_W:0]     r;
    logic signed [OUT_W-1:0]   res;

    sh = (int'(shift) >= ACC_W) ? SHIFT_W'(ACC_W - 1) : shift;
    x  = {acc[ACC_W-1], acc};

    if (sh == '0) begin
      rnd = '0;
      t   = x;
      r   = x;
    end else begin
      rnd = (ACC_W + 1)'(1) << (sh - SHIFT_W'(1));
      t   = x + rnd;
      r   = t >>> sh;
    end

`ifdef DRAIN_RELU_EN
    if (r < 0) begin
      r = '0;
    end
`endif

    if (r > (ACC_W + 1)'(OUT_MAX)) begin
      res = OUT_W'(OUT_MAX);
    end else if (r < (ACC_W + 1)'(OUT_MIN)) begin
      res = OUT_W'(OUT_MIN);
    end else begin
      res = r[OUT_W-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/acc_drain_requant_lane.sv
// requant_lane: combinational requantizer for a single accumulator lane.
//   acc   in  ACC_W    signed accumulator value
//   shift in  SHIFT_W  right-shift amount
//   q     out OUT_W    rounded, saturated result (ReLU when DRAIN_RELU_EN is defined)
module requant_lane
  import sa_pkg::*;
(
  input  logic [ACC_W-1:0]   acc,
  input  logic [SHIFT_W-1:0] shift,
  output logic [OUT_W-1:0]   q
);

  assign q = requant($signed(acc), shift);

endmodule

// File: rtl/acc_drain.sv
// acc_drain: snapshots a row of MAC accumulators on start (clearing the MACs
// on the same edge), requantizes every lane in parallel and streams the
// results out one element per valid/ready handshake.
//   clk, rst_n (synchronous, active-low)
//   start, acc_in, shift      : drain request, packed accumulators, shift amount
//   mac_clr                   : combinational MAC clear, asserted with an accepted start
//   busy                      : high while elements are being sent
//   out_valid/out_ready       : output handshake
//   out_data/out_idx/out_last : element, column index, final-element flag
// Build option: DRAIN_RELU_EN (negative results forced to 0).
module acc_drain
  import sa_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [N_COLS*ACC_W-1:0]  acc_in,
  input  logic [SHIFT_W-1:0]       shift,
  output logic                     mac_clr,
  output logic                     busy,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OUT_W-1:0]         out_data,
  output logic [$clog2(N_COLS)-1:0] out_idx,
  output logic                     out_last
);

  localparam int IDX_W = $clog2(N_COLS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_COLS - 1);

  logic [OUT_W-1:0] lane_q [N_COLS];

  genvar gi;
  generate
    for (gi = 0; gi < N_COLS; gi++) begin : g_lane
      requant_lane u_lane (
        .acc   (acc_in[gi*ACC_W +: ACC_W]),
        .shift (shift),
        .q     (lane_q[gi])
      );
    end
  endgenerate

  drain_state_e     state_q, state_d;
  logic             valid_q, valid_d;
  logic [IDX_W-1:0] idx_q,   idx_d;
  logic [OUT_W-1:0] snap_q [N_COLS];
  logic [OUT_W-1:0] snap_d [N_COLS];

  logic capture;
  logic xfer;

  // Start is only honoured in IDLE, so a start coinciding with the final
  // handshake (still SEND) is dropped.
  assign capture = start & (state_q == IDLE);
  assign xfer    = valid_q & out_ready;

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    idx_d   = idx_q;
    snap_d  = snap_q;
    if (capture) begin
      state_d = SEND;
      valid_d = 1'b1;
      idx_d   = '0;
      snap_d  = lane_q;
    end else if (xfer) begin
      if (idx_q == LAST_IDX) begin
        state_d = IDLE;
        valid_d = 1'b0;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      idx_q   <= '0;
      for (int i = 0; i < N_COLS; i++) begin
        snap_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
    end
  end

  // Gated by rst_n so the MACs are not held in clear by a drain request
  // that arrives while this block is itself in reset.
  assign mac_clr   = capture & rst_n;
  assign busy      = (state_q == SEND);
  assign out_valid = valid_q;
  assign out_idx   = idx_q;
  assign out_data  = snap_q[idx_q];
  assign out_last  = valid_q & (idx_q == LAST_IDX);

endmodule
